// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler
// Walks the 3x3 dual-window convolution engine across a full IMG_W x IMG_H
// image. Each engine run covers two horizontally adjacent output windows
// (col and col+stride). The scheduler issues the run, waits for the engine's
// done edge, and then writes one or two result bytes into a dense row-major
// output map.
module conv_tile_scheduler #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = 3,
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [ADDR_W-1:0] i_src_base,
   input  logic [ADDR_W-1:0] i_kernel_base,
   input  logic [ADDR_W-1:0] i_dst_base,
   input  logic [2:0]        i_stride,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_eng_start,
   output logic [ADDR_W-1:0] o_eng_src_addr,
   output logic [ADDR_W-1:0] o_eng_kernel_addr,
   output logic [2:0]        o_eng_stride,
   input  logic              i_eng_done,
   input  logic [7:0]        i_eng_sum1,
   input  logic [7:0]        i_eng_sum2,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [7:0]        o_wr_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WR1   = 3'd3;
   localparam logic [2:0] S_WR2   = 3'd4;
   localparam logic [2:0] S_ADV   = 3'd5;
   localparam logic [2:0] S_FIN   = 3'd6;

   // Column/row counters must hold the look-ahead position (current + 2*stride
   // + K, and current + stride + K) without wrapping, with stride up to 7.
   localparam int CW = $clog2(IMG_W + 2*7 + K + 1);
   localparam int RW = $clog2(IMG_H + 7 + K + 1);

   localparam logic [CW-1:0]     IMG_W_C = CW'(IMG_W);
   localparam logic [CW-1:0]     K_C     = CW'(K);
   localparam logic [RW-1:0]     IMG_H_R = RW'(IMG_H);
   localparam logic [RW-1:0]     K_R     = RW'(K);
   localparam logic [ADDR_W-1:0] PITCH_A = ADDR_W'(IMG_W);

   logic [2:0]        state;
   logic [ADDR_W-1:0] dst_r;
   logic [ADDR_W-1:0] row_addr;
   logic [ADDR_W-1:0] out_idx;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [7:0]        sum2_r;
   logic              done_q;

   logic [2:0]        eff_stride;
   logic [CW-1:0]     stride_c;
   logic [RW-1:0]     stride_rw;
   logic [ADDR_W-1:0] stride_a;
   logic              pair2_ok;
   logic [CW-1:0]     col_next;
   logic              col_fits;
   logic [RW-1:0]     row_next;
   logic              row_fits;
   logic [ADDR_W-1:0] row_addr_next;
   logic              done_edge;

   // Window geometry: second-window validity and next run / next row positions.
   always_comb begin
      eff_stride    = (i_stride == 3'd0) ? 3'd1 : i_stride;
      stride_c      = CW'(o_eng_stride);
      stride_rw     = RW'(o_eng_stride);
      stride_a      = ADDR_W'(o_eng_stride);
      pair2_ok      = (col + stride_c + K_C) <= IMG_W_C;
      col_next      = col + (stride_c << 1);
      col_fits      = (col_next + K_C) <= IMG_W_C;
      row_next      = row + stride_rw;
      row_fits      = (row_next + K_R) <= IMG_H_R;
      row_addr_next = row_addr + stride_a * PITCH_A;
      done_edge     = i_eng_done & ~done_q;
   end

   // Strobes are state decodes, suppressed combinationally by an abort.
   assign o_busy      = (state != S_IDLE);
   assign o_eng_start = (state == S_ISSUE) && !i_abort;
   assign o_wr_en     = ((state == S_WR1) || (state == S_WR2)) && !i_abort;
   assign o_done      = (state == S_FIN) && !i_abort;

   // Sequencer: layer setup, engine handshake, result writes and raster advance.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state             <= S_IDLE;
         done_q            <= 1'b0;
         dst_r             <= '0;
         row_addr          <= '0;
         out_idx           <= '0;
         col               <= '0;
         row               <= '0;
         sum2_r            <= '0;
         o_eng_src_addr    <= '0;
         o_eng_kernel_addr <= '0;
         o_eng_stride      <= 3'd1;
         o_wr_addr         <= '0;
         o_wr_data         <= '0;
      end else begin
         done_q <= i_eng_done;
         if ((state != S_IDLE) && i_abort) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (i_start) begin
                     o_eng_src_addr    <= i_src_base;
                     o_eng_kernel_addr <= i_kernel_base;
                     o_eng_stride      <= eff_stride;
                     dst_r             <= i_dst_base;
                     row_addr          <= i_src_base;
                     col               <= '0;
                     row               <= '0;
                     out_idx           <= '0;
                     state             <= S_ISSUE;
                  end
               end
               S_ISSUE: state <= S_WAIT;
               S_WAIT: begin
                  if (done_edge) begin
                     o_wr_data <= i_eng_sum1;
                     o_wr_addr <= dst_r + out_idx;
                     sum2_r    <= i_eng_sum2;
                     state     <= S_WR1;
                  end
               end
               S_WR1: begin
                  if (pair2_ok) begin
                     o_wr_data <= sum2_r;
                     o_wr_addr <= dst_r + out_idx + ADDR_W'(1);
                     state     <= S_WR2;
                  end else begin
                     state <= S_ADV;
                  end
               end
               S_WR2: state <= S_ADV;
               S_ADV: begin
                  out_idx <= out_idx + (pair2_ok ? ADDR_W'(2) : ADDR_W'(1));
                  if (col_fits) begin
                     col            <= col_next;
                     o_eng_src_addr <= row_addr + ADDR_W'(col_next);
                     state          <= S_ISSUE;
                  end else begin
                     col            <= '0;
                     row            <= row_next;
                     row_addr       <= row_addr_next;
                     o_eng_src_addr <= row_addr_next;
                     state          <= row_fits ? S_ISSUE : S_FIN;
                  end
               end
               S_FIN:   state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Testbench for conv_tile_scheduler: randomized engine latency/hold and layer
// parameters, checked against a raster-scan reference of the output map.
module tb_conv_tile_scheduler;

   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int K      = 3;
   localparam int ADDR_W = 10;
   localparam int AMASK  = (1 << ADDR_W) - 1;

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic              i_start;
   logic              i_abort;
   logic [ADDR_W-1:0] i_src_base;
   logic [ADDR_W-1:0] i_kernel_base;
   logic [ADDR_W-1:0] i_dst_base;
   logic [2:0]        i_stride;
   logic              o_busy;
   logic              o_done;
   logic              o_eng_start;
   logic [ADDR_W-1:0] o_eng_src_addr;
   logic [ADDR_W-1:0] o_eng_kernel_addr;
   logic [2:0]        o_eng_stride;
   logic              i_eng_done;
   logic [7:0]        i_eng_sum1;
   logic [7:0]        i_eng_sum2;
   logic              o_wr_en;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [7:0]        o_wr_data;

   always #5 i_clk = ~i_clk;

   conv_tile_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
      .i_src_base(i_src_base), .i_kernel_base(i_kernel_base), .i_dst_base(i_dst_base),
      .i_stride(i_stride), .o_busy(o_busy), .o_done(o_done), .o_eng_start(o_eng_start),
      .o_eng_src_addr(o_eng_src_addr), .o_eng_kernel_addr(o_eng_kernel_addr),
      .o_eng_stride(o_eng_stride), .i_eng_done(i_eng_done), .i_eng_sum1(i_eng_sum1),
      .i_eng_sum2(i_eng_sum2), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
   );

   typedef struct {
      logic [ADDR_W-1:0] src;
      logic [ADDR_W-1:0] kern;
      logic [2:0]        str;
      int                cyc;
   } start_rec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      int                cyc;
   } wr_rec_t;

   start_rec_t st_q[$];
   wr_rec_t    wr_q[$];
   int         rise_q[$];
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         cyc = 0;
   int         n_vec = 0;
   int         n_err = 0;

   int                eng_cnt = 0;
   int                eng_hold = 0;
   logic [ADDR_W-1:0] eng_src = '0;
   bit                eng_kill = 1'b0;
   int                fix_delay = 0;
   int                fix_hold = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Output monitor, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge i_clk);
         if (o_eng_start) st_q.push_back('{o_eng_src_addr, o_eng_kernel_addr, o_eng_stride, cyc});
         if (o_wr_en) wr_q.push_back('{o_wr_addr, o_wr_data, cyc});
         if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // Engine model: done rises some cycles after a start, holds 1..3 cycles,
   // sums derived from the source address it was started with.
   initial begin
      i_eng_done = 1'b0;
      i_eng_sum1 = '0;
      i_eng_sum2 = '0;
      forever begin
         @(negedge i_clk);
         if (eng_kill || !i_rst_n) begin
            eng_cnt    = 0;
            eng_hold   = 0;
            i_eng_done = 1'b0;
         end else begin
            if (eng_hold > 0) begin
               eng_hold--;
               if (eng_hold == 0) i_eng_done = 1'b0;
            end
            if (eng_cnt > 0) begin
               eng_cnt--;
               if (eng_cnt == 0) begin
                  i_eng_done = 1'b1;
                  i_eng_sum1 = eng_src[7:0];
                  i_eng_sum2 = eng_src[7:0] + 8'd1;
                  eng_hold   = (fix_hold > 0) ? fix_hold : int'($urandom_range(1, 3));
                  rise_q.push_back(cyc);
               end
            end
            if (o_eng_start) begin
               eng_cnt = (fix_delay > 0) ? fix_delay : int'($urandom_range(1, 14));
               eng_src = o_eng_src_addr;
            end
         end
      end
   end

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_busy"},     o_busy, 0);
      check_val({pfx, "_done"},     o_done, 0);
      check_val({pfx, "_eng_start"}, o_eng_start, 0);
      check_val({pfx, "_wr_en"},    o_wr_en, 0);
      check_val({pfx, "_src_addr"}, o_eng_src_addr, 0);
      check_val({pfx, "_kern_addr"}, o_eng_kernel_addr, 0);
      check_val({pfx, "_stride"},   o_eng_stride, 1);
      check_val({pfx, "_wr_addr"},  o_wr_addr, 0);
      check_val({pfx, "_wr_data"},  o_wr_data, 0);
   endtask

   // Clear engine and scoreboard, then pulse start for one cycle.
   task automatic start_layer(input int stride, input int src, input int kern, input int dst,
                              output int scyc);
      eng_kill = 1'b1;
      @(negedge i_clk);
      @(posedge i_clk); #1;
      eng_kill = 1'b0;
      st_q.delete();
      wr_q.delete();
      rise_q.delete();
      done_cnt = 0;
      i_src_base    = ADDR_W'(src);
      i_kernel_base = ADDR_W'(kern);
      i_dst_base    = ADDR_W'(dst);
      i_stride      = 3'(stride);
      i_start       = 1'b1;
      scyc          = cyc;
      @(posedge i_clk); #1;
      i_start       = 1'b0;
      i_src_base    = ADDR_W'($urandom);
      i_kernel_base = ADDR_W'($urandom);
      i_dst_base    = ADDR_W'($urandom);
      i_stride      = 3'($urandom);
   endtask

   // Reference: raster over window positions; output index is the dense
   // row-major coordinate (row/stride, col/stride) of each window.
   task automatic check_layer(input int src, input int kern, input int dst, input int stride_in,
                              input int scyc);
      int s;
      int out_w;
      int run;
      int wi;
      int last_wc;
      s       = (stride_in == 0) ? 1 : stride_in;
      out_w   = (IMG_W - K) / s + 1;
      run     = 0;
      wi      = 0;
      last_wc = -1;
      for (int r = 0; r + K <= IMG_H; r += s) begin
         for (int c = 0; c + K <= IMG_W; c += 2 * s) begin
            int es;
            int idx;
            bit two;
            es  = (src + r * IMG_W + c) & AMASK;
            idx = (r / s) * out_w + c / s;
            two = (c + s + K <= IMG_W);
            if (run < st_q.size()) begin
               check_val("start_src", st_q[run].src, es);
               check_val("start_kern", st_q[run].kern, kern & AMASK);
               check_val("start_stride", st_q[run].str, s);
               if (run == 0) check_val("start_latency", st_q[0].cyc, scyc + 1);
               else if (last_wc >= 0) check_val("wr_to_start", st_q[run].cyc, last_wc + 2);
            end
            if (wi < wr_q.size()) begin
               check_val("wr1_addr", wr_q[wi].addr, (dst + idx) & AMASK);
               check_val("wr1_data", wr_q[wi].data, es & 255);
               if (run < rise_q.size()) check_val("done_to_wr1", wr_q[wi].cyc, rise_q[run] + 1);
               last_wc = wr_q[wi].cyc;
            end
            wi++;
            if (two) begin
               if (wi < wr_q.size()) begin
                  check_val("wr2_addr", wr_q[wi].addr, (dst + idx + 1) & AMASK);
                  check_val("wr2_data", wr_q[wi].data, (es + 1) & 255);
                  check_val("wr1_to_wr2", wr_q[wi].cyc, last_wc + 1);
                  last_wc = wr_q[wi].cyc;
               end
               wi++;
            end
            run++;
         end
      end
      check_val("start_count", st_q.size(), run);
      check_val("write_count", wr_q.size(), wi);
      check_val("done_count", done_cnt, 1);
      check_val("wr_to_done", done_cyc, last_wc + 2);
   endtask

   task automatic run_layer(input int stride, input int src, input int kern, input int dst,
                            input int fdelay, input int fhold, input bit inject_start);
      int scyc;
      fix_delay = fdelay;
      fix_hold  = fhold;
      start_layer(stride, src, kern, dst, scyc);
      for (int k = 0; k < 40000 && done_cnt == 0; k++) begin
         @(posedge i_clk); #1;
         i_start = inject_start && (k == 200 || k == 201);
      end
      i_start = 1'b0;
      check_val("layer_done_seen", done_cnt, 1);
      check_val("busy_after_done", o_busy, 0);
      check_layer(src, kern, dst, stride, scyc);
   endtask

   initial begin
      int scyc;
      int dst;
      i_rst_n       = 1'b0;
      i_start       = 1'b0;
      i_abort       = 1'b0;
      i_src_base    = '0;
      i_kernel_base = '0;
      i_dst_base    = '0;
      i_stride      = '0;
      repeat (3) @(posedge i_clk);
      #1;
      check_reset_outputs("reset");
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      run_layer(1, 0, 0, 0, 12, 1, 1'b0);
      run_layer(2, $urandom_range(0, AMASK), $urandom_range(0, AMASK), $urandom_range(0, AMASK), 0, 0, 1'b1);
      run_layer(3, $urandom_range(0, AMASK), $urandom_range(0, AMASK), $urandom_range(0, AMASK), 0, 0, 1'b0);
      run_layer(0, $urandom_range(0, AMASK), $urandom_range(0, AMASK), $urandom_range(0, AMASK), 0, 0, 1'b0);
      run_layer(1, $urandom_range(0, AMASK), $urandom_range(0, AMASK), $urandom_range(0, AMASK), 0, 3, 1'b1);
      run_layer($urandom_range(4, 7), $urandom_range(0, AMASK), $urandom_range(0, AMASK),
                $urandom_range(0, AMASK), 0, 0, 1'b1);

      // Abort while waiting on the fifth engine run.
      fix_delay = 12;
      fix_hold  = 1;
      dst       = $urandom_range(0, AMASK);
      start_layer(1, $urandom_range(0, AMASK), $urandom_range(0, AMASK), dst, scyc);
      for (int k = 0; k < 5000 && st_q.size() < 5; k++) begin
         @(posedge i_clk); #1;
      end
      i_abort = 1'b1;
      @(posedge i_clk); #1;
      i_abort = 1'b0;
      check_val("abort_wait_busy", o_busy, 0);
      repeat (40) @(posedge i_clk);
      #1;
      check_val("abort_wait_starts", st_q.size(), 5);
      check_val("abort_wait_writes", wr_q.size(), 8);
      check_val("abort_wait_done", done_cnt, 0);
      if (wr_q.size() >= 8) check_val("abort_wait_last_addr", wr_q[7].addr, (dst + 7) & AMASK);
      run_layer(3, $urandom_range(0, AMASK), $urandom_range(0, AMASK), $urandom_range(0, AMASK), 0, 0, 1'b0);

      // Abort in the same cycle as the engine start.
      start_layer(2, $urandom_range(0, AMASK), $urandom_range(0, AMASK), $urandom_range(0, AMASK), scyc);
      for (int k = 0; k < 100 && !o_eng_start; k++) begin
         @(posedge i_clk); #1;
      end
      i_abort = 1'b1;
      #1;
      check_val("abort_gates_start", o_eng_start, 0);
      @(posedge i_clk); #1;
      i_abort = 1'b0;
      check_val("abort_issue_busy", o_busy, 0);
      repeat (20) @(posedge i_clk);
      #1;
      check_val("abort_issue_starts", st_q.size(), 0);
      check_val("abort_issue_done", done_cnt, 0);

      // Reset asserted during the first result write.
      fix_delay = 0;
      fix_hold  = 0;
      start_layer(2, $urandom_range(0, AMASK), $urandom_range(0, AMASK), $urandom_range(0, AMASK), scyc);
      for (int k = 0; k < 100 && !o_wr_en; k++) begin
         @(posedge i_clk); #1;
      end
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      check_reset_outputs("midreset");
      i_rst_n = 1'b1;
      repeat (40) @(posedge i_clk);
      #1;
      check_val("midreset_writes", wr_q.size(), 1);
      check_val("midreset_done", done_cnt, 0);
      check_val("midreset_busy", o_busy, 0);
      run_layer(1, $urandom_range(0, AMASK), $urandom_range(0, AMASK), $urandom_range(0, AMASK), 0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
